// File: rtl/qbus_target_if.sv
// Bus-side signals between the CPU bus master and qbus_target.
// Suffixes follow the target's point of view (_i into the target, _o out of it).
interface qbus_target_if;
  logic        sync_i;
  logic        din_i;
  logic        dout_i;
  logic        wtbt_i;
  logic [15:0] addr_i;
  logic [15:0] wdata_i;
  logic        rply_o;
  logic        error_o;
  logic [15:0] rdata_o;

  modport master (
    output sync_i, din_i, dout_i, wtbt_i, addr_i, wdata_i,
    input  rply_o, error_o, rdata_o
  );

  modport slave (
    input  sync_i, din_i, dout_i, wtbt_i, addr_i, wdata_i,
    output rply_o, error_o, rdata_o
  );
endinterface

// File: rtl/qbus_target.sv
// Q-bus target: RAM window with programmable wait states, timeout error on unmapped accesses.
// Define QBUS_TARGET_SEL_REGS_EN to decode the 177714/177716 select registers internally.
module qbus_target #(
  parameter logic [15:0] RAM_BASE    = 16'o100000,
  parameter int          RAM_WORDS   = 1024,
  parameter int          WAIT_STATES = 1,
  parameter int          TIMEOUT     = 63
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         ce,
  qbus_target_if.slave bus,
  output logic         mem_cs_o,
  output logic         mem_we_o,
  output logic [1:0]   mem_be_o,
  output logic [14:0]  mem_addr_o,
  output logic [15:0]  mem_wdata_o,
  input  logic [15:0]  mem_rdata_i,
  input  logic [15:0]  sel1_i,
  output logic [15:0]  sel1_o,
  output logic [15:0]  sel2_o
);

  localparam int              CW        = 16;
  localparam logic [16:0]     RAM_LO    = {1'b0, RAM_BASE};
  localparam logic [16:0]     RAM_HI    = RAM_LO + 17'(2 * RAM_WORDS);
  localparam logic [14:0]     WORD_MASK = 15'(RAM_WORDS - 1);
  localparam logic [CW-1:0]   WAIT_LOAD = CW'((WAIT_STATES > 1) ? WAIT_STATES - 1 : 0);
  localparam logic [CW-1:0]   MISS_LOAD = CW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_ACCESS, S_WAIT, S_REPLY, S_MISS, S_ERR, S_SELREG
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [15:0]     addr_reg, addr_next;
  logic            wtbt_reg, wtbt_next;
  logic            write_reg, write_next;
  logic [15:0]     rdata_reg, rdata_next;
  logic            sync_q;

  logic            sync_rise;
  logic            dir_ok;
  logic            ram_hit;
  logic            sel_hit;
  logic [15:0]     offset;

  assign sync_rise = bus.sync_i & ~sync_q;
  assign dir_ok    = bus.din_i ^ bus.dout_i;
  assign ram_hit   = ({1'b0, bus.addr_i} >= RAM_LO) && ({1'b0, bus.addr_i} < RAM_HI);

`ifdef QBUS_TARGET_SEL_REGS_EN
  localparam logic [15:0] SEL2_ADDR = 16'o177714;
  assign sel_hit = (bus.addr_i[15:2] == SEL2_ADDR[15:2]);
`else
  assign sel_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      addr_reg  <= '0;
      wtbt_reg  <= 1'b0;
      write_reg <= 1'b0;
      rdata_reg <= '0;
      sync_q    <= 1'b0;
    end else if (ce) begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      addr_reg  <= addr_next;
      wtbt_reg  <= wtbt_next;
      write_reg <= write_next;
      rdata_reg <= rdata_next;
      sync_q    <= bus.sync_i;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    addr_next  = addr_reg;
    wtbt_next  = wtbt_reg;
    write_next = write_reg;
    rdata_next = rdata_reg;
    case (state_reg)
      S_IDLE: begin
        // Cycle attributes are captured once, at the SYNC rise only
        if (sync_rise) begin
          addr_next  = bus.addr_i;
          wtbt_next  = bus.wtbt_i;
          write_next = bus.dout_i;
          if (dir_ok && sel_hit) begin
            state_next = S_SELREG;
          end else if (dir_ok && ram_hit) begin
            state_next = S_ACCESS;
          end else begin
            state_next = S_MISS;
            cnt_next   = MISS_LOAD;
          end
        end
      end
      S_ACCESS: begin
        if (!bus.sync_i) begin
          state_next = S_IDLE;
        end else begin
          cnt_next   = WAIT_LOAD;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!bus.sync_i) begin
          state_next = S_IDLE;
        end else if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CW'(1);
        end else begin
          if (!write_reg) rdata_next = mem_rdata_i;
          state_next = S_REPLY;
        end
      end
      S_REPLY: begin
        if (!bus.sync_i) begin
          rdata_next = '0;
          state_next = S_IDLE;
        end
      end
      S_MISS: begin
        // ERR is reached on the ce-cycle the count would hit zero
        if (!bus.sync_i) begin
          state_next = S_IDLE;
        end else if (cnt_reg <= CW'(1)) begin
          cnt_next   = '0;
          state_next = S_ERR;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      S_ERR: begin
        if (!bus.sync_i) state_next = S_IDLE;
      end
      S_SELREG: begin
`ifdef QBUS_TARGET_SEL_REGS_EN
        if (!write_reg) rdata_next = addr_reg[1] ? sel1_i : sel2_o;
        state_next = S_REPLY;
`else
        state_next = S_IDLE;
`endif
      end
      default: state_next = S_IDLE;
    endcase
  end

`ifdef QBUS_TARGET_SEL_REGS_EN
  // One byte lane per generate instance; word writes enable both lanes
  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    logic [7:0] sel1_b;
    logic [7:0] sel2_b;
    logic       lane_we;

    assign lane_we = ce && (state_reg == S_SELREG) && write_reg &&
                     (!wtbt_reg || (addr_reg[0] == 1'(gi)));

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        sel1_b <= '0;
        sel2_b <= '0;
      end else if (lane_we) begin
        if (addr_reg[1]) sel1_b <= bus.wdata_i[gi*8 +: 8];
        else             sel2_b <= bus.wdata_i[gi*8 +: 8];
      end
    end
  end

  assign sel1_o = {g_lane[1].sel1_b, g_lane[0].sel1_b};
  assign sel2_o = {g_lane[1].sel2_b, g_lane[0].sel2_b};

  logic unused_bits;
  assign unused_bits = offset[0];
`else
  assign sel1_o = '0;
  assign sel2_o = '0;

  logic unused_bits;
  assign unused_bits = ^{offset[0], sel1_i};
`endif

  assign offset      = addr_reg - RAM_BASE;
  assign mem_cs_o    = (state_reg == S_ACCESS);
  assign mem_we_o    = mem_cs_o & write_reg;
  assign mem_addr_o  = mem_cs_o ? (offset[15:1] & WORD_MASK) : '0;
  assign mem_wdata_o = bus.wdata_i;

  always_comb begin
    mem_be_o = 2'b00;
    if (mem_cs_o) begin
      if (write_reg && wtbt_reg) mem_be_o = addr_reg[0] ? 2'b10 : 2'b01;
      else                       mem_be_o = 2'b11;
    end
  end

  assign bus.rply_o  = (state_reg == S_REPLY);
  assign bus.error_o = (state_reg == S_ERR);
  assign bus.rdata_o = rdata_reg;

endmodule

// File: tb/tb_qbus_target.sv
// Randomized bench for qbus_target: a RAM stub serves the strobes, a word-level model predicts results.
`timescale 1ns/1ps
module tb_qbus_target;

  localparam logic [15:0] RAM_BASE  = 16'o100000;
  localparam int          RAM_WORDS = 1024;
  localparam int          WS        = 3;
  localparam int          TO        = 63;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ce;
  logic        mem_cs, mem_we;
  logic [1:0]  mem_be;
  logic [14:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic [15:0] sel1_in, sel1_out, sel2_out;

  qbus_target_if bus_if ();

  qbus_target #(
    .RAM_BASE(RAM_BASE), .RAM_WORDS(RAM_WORDS), .WAIT_STATES(WS), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .bus(bus_if),
    .mem_cs_o(mem_cs), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .sel1_i(sel1_in), .sel1_o(sel1_out), .sel2_o(sel2_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] seed_word(input int i);
    return 16'(i * 40503) ^ 16'h5a5a;
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] wd,
                                        input logic byte_op, input logic odd);
    logic [15:0] r;
    r = old;
    if (!byte_op || !odd) r[7:0]  = wd[7:0];
    if (!byte_op || odd)  r[15:8] = wd[15:8];
    return r;
  endfunction

  // RAM stub: one-ce-cycle registered read, lane-wise writes
  logic [15:0] ram_q [RAM_WORDS];
  bit   [1:0]  ram_wr [RAM_WORDS];
  logic [15:0] stub_seed;
  assign stub_seed = seed_word(int'(mem_addr[9:0]));

  always @(posedge clk) begin
    if (ce && mem_cs) begin
      for (int l = 0; l < 2; l++) begin
        if (mem_we) begin
          if (mem_be[l]) begin
            ram_q[mem_addr[9:0]][l*8 +: 8]  <= mem_wdata[l*8 +: 8];
            ram_wr[mem_addr[9:0]][l]        <= 1'b1;
          end
        end else begin
          mem_rdata[l*8 +: 8] <= ram_wr[mem_addr[9:0]][l] ? ram_q[mem_addr[9:0]][l*8 +: 8]
                                                          : stub_seed[l*8 +: 8];
        end
      end
    end
  end

  logic [15:0] ref_mem [RAM_WORDS];
  logic [15:0] ref_sel1 = '0;
  logic [15:0] ref_sel2 = '0;
  int          txn = 0;

  // One ce-cycle, with a random number of idle clocks in front of it
  task automatic step();
    ce = 1'b0;
    repeat ($urandom_range(0, 2)) @(posedge clk);
    #1 ce = 1'b1;
    @(posedge clk);
    #1 ce = 1'b0;
  endtask

  // dir: 0 read, 1 write, 2 DIN+DOUT, 3 neither
  task automatic do_access(input logic [15:0] a, input int dir, input logic byte_op,
                           input logic [15:0] wd, input int abort_at);
    int          cls, exp_lat, widx, resp_k, cs_cnt, h;
    logic        is_wr, in_sel, in_ram, got_rply, got_err, cs_we;
    logic [1:0]  cs_be, exp_be;
    logic [14:0] cs_addr;
    logic [15:0] exp_rd, rd_seen;

    is_wr  = (dir == 1);
    widx   = ((int'(a) - int'(RAM_BASE)) >>> 1) & (RAM_WORDS - 1);
    in_ram = (int'(a) >= int'(RAM_BASE)) && (int'(a) < int'(RAM_BASE) + 2 * RAM_WORDS);
    in_sel = 1'b0;
`ifdef QBUS_TARGET_SEL_REGS_EN
    in_sel = ((a & 16'hfffc) == 16'o177714);
`endif
    cls = 2;
    if (dir < 2 && in_sel)      cls = 1;
    else if (dir < 2 && in_ram) cls = 0;
    exp_lat = (cls == 0) ? 2 + WS : (cls == 1) ? 2 : TO + 1;
    exp_be  = (!is_wr || !byte_op) ? 2'b11 : (a[0] ? 2'b10 : 2'b01);
    exp_rd  = '0;
    if (!is_wr && cls == 0) exp_rd = ref_mem[widx];
    if (!is_wr && cls == 1) exp_rd = a[1] ? sel1_in : ref_sel2;

    bus_if.addr_i  = a;
    bus_if.wtbt_i  = byte_op;
    bus_if.wdata_i = wd;
    case (dir)
      0:       {bus_if.din_i, bus_if.dout_i} = 2'b10;
      1:       {bus_if.din_i, bus_if.dout_i} = 2'b01;
      2:       {bus_if.din_i, bus_if.dout_i} = 2'b11;
      default: {bus_if.din_i, bus_if.dout_i} = 2'b00;
    endcase
    bus_if.sync_i = 1'b1;

    resp_k = 0; cs_cnt = 0; got_rply = 0; got_err = 0; rd_seen = '0;
    cs_we = 0; cs_be = '0; cs_addr = '0;
    for (int k = 1; k <= exp_lat + 4; k++) begin
      step();
      if (k == 1) begin
        bus_if.addr_i = 16'($urandom);
        bus_if.wtbt_i = ~byte_op;
        #1;
      end
      if (mem_cs) begin
        cs_cnt++;
        cs_we = mem_we; cs_be = mem_be; cs_addr = mem_addr;
      end
      if (abort_at == k) bus_if.sync_i = 1'b0;
      if ((bus_if.rply_o || bus_if.error_o) && resp_k == 0) begin
        resp_k   = k;
        got_rply = bus_if.rply_o;
        got_err  = bus_if.error_o;
        rd_seen  = bus_if.rdata_o;
        if (abort_at == 0) break;
      end
    end

    if (abort_at != 0) begin
      chk("abort_quiet", resp_k, 0);
    end else begin
      chk("latency", resp_k, exp_lat);
      chk("rply", got_rply, cls != 2);
      chk("error", got_err, cls == 2);
      chk("rdata", rd_seen, exp_rd);
      h = $urandom_range(0, 2);
      for (int j = 0; j < h; j++) begin
        step();
        chk("hold", {bus_if.rply_o, bus_if.error_o, bus_if.rdata_o}, {cls != 2, cls == 2, exp_rd});
      end
      bus_if.sync_i = 1'b0;
    end
    step();
    chk("release", {bus_if.rply_o, bus_if.error_o, bus_if.rdata_o}, 0);
    chk("cs_count", cs_cnt, cls == 0);
    if (cls == 0 && cs_cnt == 1) begin
      chk("mem_we", cs_we, is_wr);
      chk("mem_be", cs_be, exp_be);
      chk("mem_addr", cs_addr, widx);
    end

    if (is_wr && cls == 0) ref_mem[widx] = merge(ref_mem[widx], wd, byte_op, a[0]);
    if (is_wr && cls == 1) begin
      if (a[1]) ref_sel1 = merge(ref_sel1, wd, byte_op, a[0]);
      else      ref_sel2 = merge(ref_sel2, wd, byte_op, a[0]);
    end
    chk("sel1_o", sel1_out, ref_sel1);
    chk("sel2_o", sel2_out, ref_sel2);

    txn++;
    $display("txn %0d addr=%06o dir=%0d byte=%0d wd=%06o abort=%0d cls=%0d resp_at=%0d rdata=%06o",
             txn, a, dir, byte_op, wd, abort_at, cls, resp_k, rd_seen);
  endtask

  // Reset asserted while REPLY is held, with ce low
  task automatic reset_in_reply(input logic [15:0] a);
    int widx;
    widx = ((int'(a) - int'(RAM_BASE)) >>> 1) & (RAM_WORDS - 1);
    bus_if.addr_i = a; bus_if.wtbt_i = 1'b0;
    {bus_if.din_i, bus_if.dout_i} = 2'b10;
    bus_if.sync_i = 1'b1;
    for (int k = 0; k < 2 + WS + 4 && !bus_if.rply_o; k++) step();
    chk("rst_reach_reply", bus_if.rply_o, 1);
    chk("rst_pre_rdata", bus_if.rdata_o, ref_mem[widx]);
    reset_n = 1'b0;
    ce      = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_rply", bus_if.rply_o, 0);
    chk("rst_rdata", bus_if.rdata_o, 0);
    chk("rst_error", bus_if.error_o, 0);
    chk("rst_cs", mem_cs, 0);
    bus_if.sync_i = 1'b0;
    reset_n = 1'b1;
    step();
    ref_sel1 = '0;
    ref_sel2 = '0;
    chk("rst_sel", {sel1_out, sel2_out}, {ref_sel1, ref_sel2});
    txn++;
    $display("txn %0d reset during reply addr=%06o", txn, a);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog sim_time=%0t limit=800000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int          r, dir, ab;
    logic [15:0] a;
    logic        bo;

    for (int i = 0; i < RAM_WORDS; i++) ref_mem[i] = seed_word(i);
    reset_n = 1'b0; ce = 1'b0; sel1_in = '0;
    bus_if.sync_i = 0; bus_if.din_i = 0; bus_if.dout_i = 0; bus_if.wtbt_i = 0;
    bus_if.addr_i = '0; bus_if.wdata_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_bus", {bus_if.rply_o, bus_if.error_o, bus_if.rdata_o}, 0);
    chk("reset_mem", {mem_cs, mem_we, mem_be, mem_addr}, 0);
    chk("reset_sel", {sel1_out, sel2_out}, 0);
    reset_n = 1'b1;
    step();

    do_access(16'o100002, 0, 1'b0, 16'o0, 0);
    do_access(16'o100005, 1, 1'b1, 16'o177400, 0);
    do_access(16'o100004, 0, 1'b0, 16'o0, 0);
    do_access(16'o060000, 0, 1'b0, 16'o0, 0);
    do_access(16'o100010, 0, 1'b0, 16'o0, 2);
    do_access(16'o100010, 0, 1'b0, 16'o0, 0);
    do_access(16'o100020, 2, 1'b0, 16'o0, 0);
    do_access(16'o100022, 3, 1'b0, 16'o0, 0);
    reset_in_reply(16'o100002);
    do_access(16'o177716, 1, 1'b0, 16'o000300, 0);
    sel1_in = 16'o140000;
    do_access(16'o177716, 0, 1'b0, 16'o0, 0);
    do_access(16'o177714, 1, 1'b1, 16'o052525, 0);
    do_access(16'o177715, 1, 1'b1, 16'o125252, 0);
    do_access(16'o177714, 0, 1'b0, 16'o0, 0);

    for (int t = 0; t < 40; t++) begin
      r   = $urandom_range(0, 99);
      bo  = 1'($urandom_range(0, 1));
      dir = $urandom_range(0, 1);
      ab  = 0;
      sel1_in = 16'($urandom);
      if (r < 55) begin
        a = RAM_BASE + 16'($urandom_range(0, 2 * RAM_WORDS - 1));
        if ($urandom_range(0, 4) == 0) ab = $urandom_range(1, 1 + WS);
      end else if (r < 65) begin
        a = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 16'o77777))
                                        : 16'($urandom_range(16'o104000, 16'o177000));
        if ($urandom_range(0, 3) == 0) ab = $urandom_range(1, TO);
      end else if (r < 75) begin
        a   = RAM_BASE + 16'($urandom_range(0, 2 * RAM_WORDS - 1));
        dir = $urandom_range(2, 3);
      end else begin
        a = 16'o177714 + 16'($urandom_range(0, 3));
      end
      do_access(a, dir, bo, 16'($urandom), ab);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
